psg_bus_sequencer: RTL and testbench

- Sequences register accesses onto a YM2149-style PSG bus (BDIR/BC/DI/DO).
- Two requesters share the PSG, e.g. the Mockingboard emulation path and an internal init/replay engine.
- Each requester submits (read/write, reg, data) into its own FIFO. Round-robin arbitration picks the next access.
- Each access is driven as a latch-address phase followed by a write or read phase. Read data is returned to the originating requester.

---
 rtl/psg_bus_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_psg_bus_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_sequencer.sv
// psg_bus_sequencer: two-requester sequencer for a YM2149-style PSG bus.
// Each requester pushes (write, addr, data) commands into its own FIFO.
// Round-robin arbitration in IDLE picks the next command. The command is
// driven as an optional LATCH phase (skipped when the PSG already holds that
// address), an ACCESS phase (write or read), and a single GAP cycle.
// Ports:
//   CLK, RESET                   clock, synchronous active-high reset
//   cache_inval                  forget the cached latched address
//   reqN_valid/ready/write/addr/data  command push interface, N = 0, 1
//   rspN_valid/data              read data returned to requester N
//   psg_bdir/bc/di, psg_do       PSG bus (registered outputs)
//   busy                         FSM active or any FIFO non-empty
module psg_bus_sequencer #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cache_inval,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_write,
    input  logic [3:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_write,
    input  logic [3:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    output logic       psg_bdir,
    output logic       psg_bc,
    output logic [7:0] psg_di,
    input  logic [7:0] psg_do,
    output logic       busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PH_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    typedef struct packed {
        logic       write;
        logic [3:0] addr;
        logic [7:0] data;
    } psg_cmd_t;

    typedef enum logic [1:0] {IDLE, LATCH, ACCESS, GAP} state_t;

    // FIFO storage and bookkeeping, index 0/1 = requester
    psg_cmd_t         fifo_mem  [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr    [2];
    logic [PTR_W-1:0] rd_ptr    [2];
    logic [CNT_W-1:0] count     [2];
    logic [CNT_W-1:0] count_nxt [2];
    psg_cmd_t         req_cmd   [2];
    logic [1:0]       req_valid;
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       nonempty;

    // Sequencer state
    state_t            state;
    logic [PH_W-1:0]   phase_cnt;
    psg_cmd_t          cmd;
    psg_cmd_t          head;
    logic              owner;
    logic              rr_ptr;
    logic              cache_valid;
    logic [3:0]        cached_addr;
    logic              grant_en;
    logic              grant_sel;
    logic              cache_hit;
    logic              phase_last;

    assign req_cmd[0] = {req0_write, req0_addr, req0_data};
    assign req_cmd[1] = {req1_write, req1_addr, req1_data};
    assign req_valid  = {req1_valid, req0_valid};
    assign push       = req_valid & ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    // Round-robin grant, evaluated only while IDLE
    always_comb begin
        grant_en  = 1'b0;
        grant_sel = 1'b0;
        if (state == IDLE) begin
            if (nonempty == 2'b11) begin
                grant_en  = 1'b1;
                grant_sel = rr_ptr;
            end else if (nonempty[0]) begin
                grant_en  = 1'b1;
                grant_sel = 1'b0;
            end else if (nonempty[1]) begin
                grant_en  = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign pop        = {grant_en & grant_sel, grant_en & ~grant_sel};
    assign head       = fifo_mem[grant_sel][rd_ptr[grant_sel]];
    // A same-cycle invalidate must not let a stale hit skip the latch
    assign cache_hit  = cache_valid && !cache_inval && (cached_addr == head.addr);
    assign phase_last = (phase_cnt == PH_W'(PHASE_CYCLES - 1));
    assign busy       = (state != IDLE) || (nonempty != 2'b00);

    // Next FIFO occupancy; push and pop in one cycle leave it unchanged
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nonempty[i]  = (count[i] != '0);
            count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ready <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count_nxt[i];
                ready[i] <= (count_nxt[i] != CNT_W'(FIFO_DEPTH));
            end
        end
    end

    // FIFO storage (no reset needed; validity tracked by count)
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= req_cmd[i];
        end
    end

    // Bus encoding of the ACCESS phase: write (1,0,data) or read (0,1,0)
    function automatic logic [9:0] access_bus(input psg_cmd_t c);
        return c.write ? {2'b10, c.data} : {2'b01, 8'h00};
    endfunction

    // Bus sequencer FSM with registered bus and response outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            cmd         <= '0;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            cache_valid <= 1'b0;
            cached_addr <= '0;
            psg_bdir    <= 1'b0;
            psg_bc      <= 1'b0;
            psg_di      <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_data   <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_data   <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (cache_inval) cache_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_en) begin
                        cmd       <= head;
                        owner     <= grant_sel;
                        rr_ptr    <= ~grant_sel;
                        phase_cnt <= '0;
                        if (cache_hit) begin
                            state <= ACCESS;
                            {psg_bdir, psg_bc, psg_di} <= access_bus(head);
                        end else begin
                            state <= LATCH;
                            {psg_bdir, psg_bc, psg_di} <= {2'b11, 4'b0000, head.addr};
                        end
                    end
                end

                LATCH: begin
                    if (phase_last) begin
                        cached_addr <= cmd.addr;
                        // Invalidate wins over the latch-exit set
                        if (!cache_inval) cache_valid <= 1'b1;
                        state     <= ACCESS;
                        phase_cnt <= '0;
                        {psg_bdir, psg_bc, psg_di} <= access_bus(cmd);
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                ACCESS: begin
                    if (phase_last) begin
                        state     <= GAP;
                        phase_cnt <= '0;
                        {psg_bdir, psg_bc, psg_di} <= '0;
                        // Read data is captured on the last ACCESS cycle
                        if (!cmd.write) begin
                            if (owner) begin
                                rsp1_valid <= 1'b1;
                                rsp1_data  <= psg_do;
                            end else begin
                                rsp0_valid <= 1'b1;
                                rsp0_data  <= psg_do;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                GAP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    {psg_bdir, psg_bc, psg_di} <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// tb_psg_bus_sequencer: scoreboard bench for psg_bus_sequencer.
// Expected bus phases and read responses are queued when a command is
// accepted; a negedge monitor pops and compares them as the DUT produces them.
module tb_psg_bus_sequencer;

    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned PHASE_CYCLES = 2;

    logic       CLK;
    logic       RESET;
    logic       cache_inval;
    logic       req0_valid, req0_ready, req0_write;
    logic [3:0] req0_addr;
    logic [7:0] req0_data;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       req1_valid, req1_ready, req1_write;
    logic [3:0] req1_addr;
    logic [7:0] req1_data;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic       psg_bdir, psg_bc;
    logic [7:0] psg_di;
    logic [7:0] psg_do;
    logic       busy;

    logic [7:0] rd_val;

    psg_bus_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .PHASE_CYCLES(PHASE_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .cache_inval(cache_inval),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .psg_bdir   (psg_bdir),
        .psg_bc     (psg_bc),
        .psg_di     (psg_di),
        .psg_do     (psg_do),
        .busy       (busy)
    );

    // PSG model: returns rd_val only while a read phase is on the bus
    assign psg_do = (!psg_bdir && psg_bc) ? rd_val : 8'hFF;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard state
    logic [31:0] exp_q[$];
    logic [7:0]  rsp_q0[$];
    logic [7:0]  rsp_q1[$];
    bit          m_cv;
    logic [3:0]  m_ca;
    int          rsp_cnt0 = 0;
    int          rsp_cnt1 = 0;
    bit          busy_chk_en = 0;
    int          busy_falls = 0;

    function automatic logic [31:0] rec(input logic [9:0] v, input int len);
        return {14'b0, v, 8'(len)};
    endfunction

    // Reference model of the expected bus phases for one accepted command
    task automatic predict(input bit side, input bit wr, input logic [3:0] a, input logic [7:0] d);
        if (!(m_cv && m_ca == a)) exp_q.push_back(rec({2'b11, 4'b0000, a}, PHASE_CYCLES));
        if (wr) begin
            exp_q.push_back(rec({2'b10, d}, PHASE_CYCLES));
        end else begin
            exp_q.push_back(rec({2'b01, 8'h00}, PHASE_CYCLES));
            if (side) rsp_q1.push_back(rd_val);
            else      rsp_q0.push_back(rd_val);
        end
        m_cv = 1'b1;
        m_ca = a;
    endtask

    // Bus and response monitor
    logic [9:0] run_val;
    int         run_len = 0;
    logic [9:0] hist1 = '0;
    logic [9:0] hist2 = '0;
    logic       prev_busy = 1'b0;

    always @(negedge CLK) begin
        logic [9:0] cur;
        cur = {psg_bdir, psg_bc, psg_di};
        if (RESET) begin
            run_len   = 0;
            hist1     = '0;
            hist2     = '0;
            prev_busy = 1'b0;
        end else begin
            if (rsp0_valid) begin
                rsp_cnt0++;
                check("rsp0_timing", 32'({hist1, cur}), 32'({10'h100, 10'h000}));
                if (rsp_q0.size() == 0) check("rsp0_unexpected", 32'(rsp0_valid), 32'h0);
                else check("rsp0_data", 32'(rsp0_data), 32'(rsp_q0.pop_front()));
            end
            if (rsp1_valid) begin
                rsp_cnt1++;
                check("rsp1_timing", 32'({hist1, cur}), 32'({10'h100, 10'h000}));
                if (rsp_q1.size() == 0) check("rsp1_unexpected", 32'(rsp1_valid), 32'h0);
                else check("rsp1_data", 32'(rsp1_data), 32'(rsp_q1.pop_front()));
            end

            if (run_len != 0 && cur == run_val) begin
                run_len++;
            end else begin
                if (run_len != 0) begin
                    if (exp_q.size() == 0) check("bus_extra", rec(run_val, run_len), 32'h0);
                    else check("bus_phase", rec(run_val, run_len), exp_q.pop_front());
                    if (run_val[9:8] != 2'b11) check("gap_after_access", 32'(cur), 32'h0);
                end
                if (cur[9:8] != 2'b00) begin
                    run_val = cur;
                    run_len = 1;
                end else begin
                    run_len = 0;
                end
            end

            if (busy_chk_en && prev_busy && !busy) begin
                busy_falls++;
                check("busy_fall_after_gap", {21'b0, hist2[9:8] != 2'b00, hist1}, {21'b0, 1'b1, 10'h000});
            end
            hist2     = hist1;
            hist1     = cur;
            prev_busy = busy;
        end
    end

    // Push one command, waiting (bounded) for ready; valid stays high afterwards
    task automatic push(input bit side, input bit wr, input logic [3:0] a,
                        input logic [7:0] d, output int stalls);
        bit rdy;
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (side) begin
                req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_data = d;
                rdy = req1_ready;
            end else begin
                req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_data = d;
                rdy = req0_ready;
            end
            if (rdy) begin
                @(posedge CLK);
                predict(side, wr, a, d);
                return;
            end
            stalls++;
        end
        check("push_accepted", 32'(stalls < 100), 32'h1);
    endtask

    task automatic release_reqs();
        @(negedge CLK);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (!busy) break;
        end
        check({tag, "_idle"}, 32'(k < 300), 32'h1);
        check({tag, "_drained"}, 32'(exp_q.size() + rsp_q0.size() + rsp_q1.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int st;
        int first_stall;
        int c0, c1;
        int k;

        RESET = 1'b1; cache_inval = 1'b0; rd_val = 8'h00;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_data = '0;
        m_cv = 1'b0; m_ca = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_outputs", 32'({rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
                                  psg_bdir, psg_bc, psg_di, busy}), 32'h0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'h3);
        @(posedge CLK);
        #1 RESET = 1'b0;

        // Single write with latch
        push(1'b0, 1'b1, 4'd7, 8'h38, st);
        release_reqs();
        wait_idle("single_write");
        check("single_write_no_rsp", 32'(rsp_cnt0 + rsp_cnt1), 32'h0);

        // Back-to-back writes to one register: second skips LATCH
        push(1'b0, 1'b1, 4'd8, 8'h0F, st);
        push(1'b0, 1'b1, 4'd8, 8'h10, st);
        release_reqs();
        wait_idle("cached_write");

        // Invalidate the cache: LATCH reappears
        @(negedge CLK);
        cache_inval = 1'b1;
        m_cv = 1'b0;
        @(negedge CLK);
        cache_inval = 1'b0;
        push(1'b0, 1'b1, 4'd8, 8'h11, st);
        release_reqs();
        wait_idle("inval_write");

        // Read by requester 1
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        rd_val = 8'hA5;
        push(1'b1, 1'b0, 4'd14, 8'h00, st);
        release_reqs();
        wait_idle("read");
        check("read_rsp1_count", 32'(rsp_cnt1 - c1), 32'h1);
        check("read_rsp0_count", 32'(rsp_cnt0 - c0), 32'h0);

        // Contention: interleaved grants, busy falls once after the last GAP
        busy_falls  = 0;
        busy_chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'(i);     req0_data = 8'h10 + 8'(i);
            req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 4'(3 + i); req1_data = 8'h20 + 8'(i);
            check("cont_ready", 32'({req0_ready, req1_ready}), 32'h3);
            @(posedge CLK);
            predict(1'b0, 1'b1, 4'(i), 8'h10 + 8'(i));
            predict(1'b1, 1'b1, 4'(3 + i), 8'h20 + 8'(i));
        end
        release_reqs();
        wait_idle("contention");
        check("cont_busy_falls", 32'(busy_falls), 32'h1);
        busy_chk_en = 1'b0;

        // Backpressure: ready drops after FIFO_DEPTH+1 accepted pushes
        first_stall = -1;
        for (int i = 0; i < 7; i++) begin
            push(1'b0, 1'b1, 4'd9, 8'h40 + 8'(i), st);
            if (st != 0 && first_stall < 0) first_stall = i;
        end
        release_reqs();
        check("bp_accepted_before_full", 32'(first_stall), 32'(FIFO_DEPTH + 1));
        wait_idle("backpressure");

        // Reset during the ACCESS phase of a read
        c1 = rsp_cnt1;
        rd_val = 8'h5A;
        push(1'b1, 1'b0, 4'd3, 8'h00, st);
        release_reqs();
        for (k = 0; k < 100; k++) begin
            @(negedge CLK);
            if ({psg_bdir, psg_bc} == 2'b01) break;
        end
        check("rst_mid_read_found", 32'(k < 100), 32'h1);
        #1 RESET = 1'b1;
        exp_q.delete();
        rsp_q0.delete();
        rsp_q1.delete();
        m_cv = 1'b0;
        @(negedge CLK);
        check("rst_mid_bus", 32'({psg_bdir, psg_bc, psg_di}), 32'h0);
        check("rst_mid_ready", 32'({req0_ready, req1_ready}), 32'h3);
        check("rst_mid_busy_rsp", 32'({busy, rsp0_valid, rsp1_valid}), 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (6) @(negedge CLK);
        check("rst_mid_no_rsp", 32'(rsp_cnt1 - c1), 32'h0);

        // First write after reset must latch again
        push(1'b0, 1'b1, 4'd3, 8'h77, st);
        release_reqs();
        wait_idle("post_reset_write");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
